wb_load_commit: RTL
===================

Name: wb_load_commit

Overview:
- Registered writeback stage that replaces the purely combinational result mux.
- Accepts one retiring instruction per handshake from the memory stage.
- Loads: waits for the data-memory response, then extracts and extends the byte/half/word lane using the low address bits.
- Drives a single registered register-file write port, with a stall indication and a timeout error for lost memory responses.

Parameters:
- XLEN, 32: datapath width; legal values 32 or 64.
- MEM_TIMEOUT, 15: max cycles spent in WAIT_MEM before forced commit; legal range 1..255.
- LANE_W, log2(XLEN/8): width of the low address field (2 for XLEN=32, 3 for XLEN=64).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  memory stage presents an instruction.
- in_ready  out  1  block can accept; combinational, equals (state==IDLE).
- alu_out  in  XLEN  ALU result.
- pc  in  XLEN  instruction PC.
- wb_mux  in  2  result select: 00 ALU, 01 PC+4, 10 DMEM, 11 no write.
- funct3  in  3  load type.
- rd_addr  in  5  destination register.
- mem_addr_lo  in  LANE_W  low bits of the load address.
- mem_rsp_valid  in  1  data-memory response strobe.
- mem_rsp_data  in  XLEN  raw, naturally aligned memory word.
- rd_we  out  1  register-file write enable, one-cycle pulse.
- rd_waddr  out  5  register-file write address.
- rd_data  out  XLEN  register-file write data.
- busy  out  1  high in WAIT_MEM; used as the pipeline stall.
- mem_err  out  1  one-cycle pulse on timeout commit.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rd_we=0, rd_waddr=0, rd_data=0, mem_err=0, timeout counter=0.
  - All captured fields are cleared.
  - Reset mid-WAIT_MEM abandons the load; no write occurs.
- States: IDLE, WAIT_MEM.
- Acceptance: occurs when in_valid && in_ready.
  - wb_mux 00: rd_data<=alu_out next cycle.
  - wb_mux 01: rd_data<=pc+4 next cycle, modulo 2^XLEN (wraps, no carry out).
  - wb_mux 11: no write; rd_we stays 0.
  - wb_mux 10: capture funct3, rd_addr and mem_addr_lo; state->WAIT_MEM; counter<=0.
- Latency: non-load commits 1 cycle after acceptance. Load commits 1 cycle after the first mem_rsp_valid seen in WAIT_MEM.
- mem_rsp_valid in IDLE is ignored. mem_rsp_valid in the acceptance cycle is ignored; the response is expected no earlier than the next cycle.
- WAIT_MEM:
  - Each cycle without a response, counter increments.
  - On mem_rsp_valid: commit the extracted data; state->IDLE.
  - Otherwise, when counter==MEM_TIMEOUT-1: commit rd_data=0, pulse mem_err; state->IDLE.
  - A response and the timeout in the same cycle: the response wins, mem_err=0.
- Lane extraction (byte offset = mem_addr_lo):
  - LB 000: sign-extend byte[offset].
  - LBU 100: zero-extend byte[offset].
  - LH 001: sign-extend half at byte offset with bit0 cleared.
  - LHU 101: zero-extend that half.
  - LW 010: word at offset[LANE_W-1:2]*4; sign-extended when XLEN=64.
  - LWU 110 (XLEN=64 only): zero-extend the word.
  - LD 011 (XLEN=64 only): full doubleword.
  - Any other funct3, or an XLEN=32 encoding of 011/110: full XLEN word, unmodified.
- x0 rule: commits targeting rd=0 keep rd_we=0; rd_data still updates.
- Between commits: rd_we=0; rd_data/rd_waddr hold their last values.
- Throughput: one non-load per cycle back-to-back; in_ready=0 throughout WAIT_MEM.

Optional Feature:
- Macro: WB_MISALIGN_TRAP_EN.
- When defined:
  - Adds output misalign (1 bit, reset 0).
  - A load accepted with a halfword at odd offset, or a word/doubleword not naturally aligned, does not enter WAIT_MEM.
  - Instead, the next cycle pulses misalign=1 with rd_we=0, and state stays IDLE.
  - A memory response for that load is ignored.
- When undefined: no port. Misaligned offsets are truncated per the lane rules above: LH at offset 3 reads the half at offset 2.

Test Plan:
- Reset release, in_valid=1, wb_mux=00, alu_out=0x1234_5678, rd=5 -> next cycle rd_we=1, rd_waddr=5, rd_data=0x1234_5678.
- wb_mux=01, pc=0xFFFF_FFFC, rd=1 -> rd_data=0x0000_0000 (wrap), rd_we=1.
- LB, lo=3, rsp 0x80FF_0000 two cycles after accept -> busy=1 for 2 cycles, in_ready=0; then rd_data=0xFFFF_FF80, rd_we=1.
- LHU, lo=2, rsp 0x8001_7777 -> rd_data=0x0000_8001. LW to rd=0 -> rd_we stays 0.
- Load with no response, MEM_TIMEOUT=4 -> after 4 WAIT_MEM cycles: mem_err=1, rd_we=1, rd_data=0, in_ready=1 again.
- Assert rst_n=0 during WAIT_MEM, then deliver the response after release -> no rd_we; with WB_MISALIGN_TRAP_EN, LW at lo=2 -> misalign=1, busy stays 0.

Source files
------------

// File: rtl/wb_load_commit_if.sv
// ---------------------------------------------------------------------------
// wb_load_commit_if
//
// Bundles the signals the writeback stage shares with its surroundings.
// These are the retiring-instruction handshake from the memory stage, the
// data-memory response, and the register-file write port.
//
//   slave  modport : the writeback stage (wb_load_commit)
//   master modport : memory stage / memory / register file side
//
// Signal summary:
//   in_valid, in_ready        : instruction handshake
//   alu_out, pc, wb_mux       : result sources and result select
//   funct3, rd_addr           : load type and destination register
//   mem_addr_lo               : low load-address bits (byte offset)
//   mem_rsp_valid/_data       : data-memory response
//   rd_we, rd_waddr, rd_data  : registered register-file write port
//   busy                      : stall while a load waits for memory
//   mem_err                   : pulse on timeout commit
//   misalign                  : only when WB_MISALIGN_TRAP_EN is defined
// ---------------------------------------------------------------------------
interface wb_load_commit_if #(
    parameter int XLEN   = 32,
    parameter int LANE_W = $clog2(XLEN / 8)
);
    logic              in_valid;
    logic              in_ready;
    logic [XLEN-1:0]   alu_out;
    logic [XLEN-1:0]   pc;
    logic [1:0]        wb_mux;
    logic [2:0]        funct3;
    logic [4:0]        rd_addr;
    logic [LANE_W-1:0] mem_addr_lo;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_data;
    logic              rd_we;
    logic [4:0]        rd_waddr;
    logic [XLEN-1:0]   rd_data;
    logic              busy;
    logic              mem_err;
`ifdef WB_MISALIGN_TRAP_EN
    logic              misalign;
`endif

    modport slave (
        input  in_valid, alu_out, pc, wb_mux, funct3, rd_addr, mem_addr_lo,
               mem_rsp_valid, mem_rsp_data,
`ifdef WB_MISALIGN_TRAP_EN
        output misalign,
`endif
        output in_ready, rd_we, rd_waddr, rd_data, busy, mem_err
    );

    modport master (
        output in_valid, alu_out, pc, wb_mux, funct3, rd_addr, mem_addr_lo,
               mem_rsp_valid, mem_rsp_data,
`ifdef WB_MISALIGN_TRAP_EN
        input  misalign,
`endif
        input  in_ready, rd_we, rd_waddr, rd_data, busy, mem_err
    );
endinterface

// File: rtl/wb_load_commit.sv
// ---------------------------------------------------------------------------
// wb_load_commit
//
// Registered writeback stage. It accepts one retiring instruction per
// handshake. ALU and PC+4 results are committed one cycle after acceptance.
// A load parks in WAIT_MEM until the data-memory response arrives. It then
// extracts the addressed byte/half/word lane and sign- or zero-extends it.
// If no response arrives within MEM_TIMEOUT cycles, the load commits zero
// and pulses mem_err.
//
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : wb_load_commit_if.slave (handshake, memory response, RF write)
//
// Parameters:
//   XLEN        : 32 or 64
//   MEM_TIMEOUT : 1..255, maximum cycles spent in WAIT_MEM
//   LANE_W      : log2(XLEN/8), width of the byte-offset field
//
// Optional feature macro: WB_MISALIGN_TRAP_EN
//   When defined, a misaligned half/word/doubleword load does not wait for
//   memory. It pulses misalign instead and writes nothing.
// ---------------------------------------------------------------------------
module wb_load_commit #(
    parameter int XLEN        = 32,
    parameter int MEM_TIMEOUT = 15,
    parameter int LANE_W      = $clog2(XLEN / 8)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    wb_load_commit_if.slave        bus
);

    typedef enum logic {
        IDLE,
        WAIT_MEM
    } state_t;

    state_t            state;
    logic [7:0]        tmo_cnt;
    logic [2:0]        cap_funct3;
    logic [4:0]        cap_rd;
    logic [LANE_W-1:0] cap_lo;
    logic [XLEN-1:0]   load_data;

    localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state == WAIT_MEM);

    // Lane extraction from the naturally aligned memory word. The offset
    // is masked down to the access size, so an unaligned half or word reads
    // the aligned container that holds it.
    logic [LANE_W+2:0] byte_sh;
    logic [LANE_W+2:0] half_sh;
    logic [LANE_W+2:0] word_sh;
    logic [XLEN-1:0]   sh_b;
    logic [XLEN-1:0]   sh_h;
    logic [XLEN-1:0]   sh_w;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [31:0]       lane_w;

    always_comb begin
        byte_sh   = {cap_lo, 3'b000};
        half_sh   = {cap_lo & ~LANE_W'(1), 3'b000};
        word_sh   = {cap_lo & ~LANE_W'(3), 3'b000};
        sh_b      = bus.mem_rsp_data >> byte_sh;
        sh_h      = bus.mem_rsp_data >> half_sh;
        sh_w      = bus.mem_rsp_data >> word_sh;
        lane_b    = sh_b[7:0];
        lane_h    = sh_h[15:0];
        lane_w    = sh_w[31:0];
        load_data = bus.mem_rsp_data;
        case (cap_funct3)
            3'b000: load_data = XLEN'($signed(lane_b));
            3'b100: load_data = XLEN'(lane_b);
            3'b001: load_data = XLEN'($signed(lane_h));
            3'b101: load_data = XLEN'(lane_h);
            3'b010: load_data = XLEN'($signed(lane_w));
            3'b110: if (XLEN == 64) load_data = XLEN'(lane_w);
            default: load_data = bus.mem_rsp_data;
        endcase
    end

`ifdef WB_MISALIGN_TRAP_EN
    // Alignment check on the incoming load, done before it would enter
    // WAIT_MEM. The 64-bit-only encodings count as misaligned only when
    // XLEN is 64.
    logic in_misaligned;

    always_comb begin
        in_misaligned = 1'b0;
        case (bus.funct3)
            3'b001, 3'b101: in_misaligned = bus.mem_addr_lo[0];
            3'b010:         in_misaligned = (bus.mem_addr_lo & LANE_W'(3)) != '0;
            3'b110:         in_misaligned = (XLEN == 64) &&
                                            ((bus.mem_addr_lo & LANE_W'(3)) != '0);
            3'b011:         in_misaligned = (XLEN == 64) && (bus.mem_addr_lo != '0);
            default:        in_misaligned = 1'b0;
        endcase
    end
`endif

    // Control FSM and registered write port. rd_we, mem_err and misalign are
    // single-cycle pulses. rd_data and rd_waddr hold between commits.
    // Writes to x0 update the data but never raise rd_we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            cap_funct3   <= '0;
            cap_rd       <= '0;
            cap_lo       <= '0;
            bus.rd_we    <= 1'b0;
            bus.rd_waddr <= '0;
            bus.rd_data  <= '0;
            bus.mem_err  <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            bus.misalign <= 1'b0;
`endif
        end else begin
            bus.rd_we   <= 1'b0;
            bus.mem_err <= 1'b0;
`ifdef WB_MISALIGN_TRAP_EN
            bus.misalign <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        case (bus.wb_mux)
                            2'b00: begin
                                bus.rd_we    <= (bus.rd_addr != 5'd0);
                                bus.rd_waddr <= bus.rd_addr;
                                bus.rd_data  <= bus.alu_out;
                            end
                            2'b01: begin
                                bus.rd_we    <= (bus.rd_addr != 5'd0);
                                bus.rd_waddr <= bus.rd_addr;
                                bus.rd_data  <= bus.pc + XLEN'(4);
                            end
                            2'b10: begin
`ifdef WB_MISALIGN_TRAP_EN
                                if (in_misaligned) begin
                                    bus.misalign <= 1'b1;
                                end else begin
                                    cap_funct3 <= bus.funct3;
                                    cap_rd     <= bus.rd_addr;
                                    cap_lo     <= bus.mem_addr_lo;
                                    tmo_cnt    <= '0;
                                    state      <= WAIT_MEM;
                                end
`else
                                cap_funct3 <= bus.funct3;
                                cap_rd     <= bus.rd_addr;
                                cap_lo     <= bus.mem_addr_lo;
                                tmo_cnt    <= '0;
                                state      <= WAIT_MEM;
`endif
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                WAIT_MEM: begin
                    // A response wins over a timeout in the same cycle.
                    if (bus.mem_rsp_valid) begin
                        bus.rd_we    <= (cap_rd != 5'd0);
                        bus.rd_waddr <= cap_rd;
                        bus.rd_data  <= load_data;
                        state        <= IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        bus.rd_we    <= (cap_rd != 5'd0);
                        bus.rd_waddr <= cap_rd;
                        bus.rd_data  <= '0;
                        bus.mem_err  <= 1'b1;
                        state        <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
